// File: rtl/key_note_tracker.sv
// Purpose: scan NUM_KEYS key lines per trigger strobe, track the active note and its hold time, emit note records.
// Latency: all outputs update on the clk_in edge that samples trigger=1 (one cycle after the sampled inputs).
// Backpressure: one-entry event register; held stable while ev_ready=0, new events dropped when full (ev_overflow).
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   keys_in, trigger          debounced key levels, one-cycle sample strobe
//   counter, key_played,      live press index (1..SEQ_LEN wrapping), key of last press,
//   note_duration             live duration of the active note in units of TICKS_PER_UNIT strobes
//   ev_valid/ev_ready         note-event handshake; ev_key/ev_duration/ev_index record fields
//   ev_overflow               sticky drop flag, cleared only by reset
//
// Build option: define KEY_NOTE_END_EVENT_EN to emit events when a note ends (release or
// pre-emption) instead of at press start.
module key_note_tracker #(
  parameter int NUM_KEYS       = 8,
  parameter int SEQ_LEN        = 8,
  parameter int TICKS_PER_UNIT = 60,
  parameter int DUR_W          = 3,
  localparam int KW            = $clog2(NUM_KEYS),
  localparam int CW            = $clog2(SEQ_LEN + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic                trigger,
  output logic [CW-1:0]       counter,
  output logic [KW-1:0]       key_played,
  output logic [DUR_W-1:0]    note_duration,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KW-1:0]       ev_key,
  output logic [DUR_W-1:0]    ev_duration,
  output logic [CW-1:0]       ev_index,
  output logic                ev_overflow
);

  localparam int TW = $clog2(TICKS_PER_UNIT);
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [NUM_KEYS-1:0]  prev_q;
  logic [KW-1:0]        act_q, act_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [CW-1:0]        counter_d;
  logic [KW-1:0]        key_d;
  logic [DUR_W-1:0]     dur_d;

  logic [NUM_KEYS-1:0]  rise;
  logic                 press;
  logic [KW-1:0]        press_key;
  logic                 held;

  logic                 gen;
  logic [KW-1:0]        gen_key;
  logic [DUR_W-1:0]     gen_dur;
  logic [CW-1:0]        gen_idx;

  always_comb begin
    rise      = keys_in & ~prev_q;
    press     = |rise;
    held      = keys_in[act_q];
    // Scan downwards so the lowest-index rising key wins.
    press_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) press_key = KW'(i);
    end

    state_d   = state_q;
    act_d     = act_q;
    tick_d    = tick_q;
    counter_d = counter;
    key_d     = key_played;
    dur_d     = note_duration;
    gen       = 1'b0;
    gen_key   = '0;
    gen_dur   = '0;
    gen_idx   = '0;

    if (trigger) begin
      if (press) begin
        // A new press always starts a note, pre-empting any active one.
        state_d   = HOLD;
        act_d     = press_key;
        tick_d    = '0;
        counter_d = (counter == CW'(SEQ_LEN)) ? CW'(1) : counter + CW'(1);
        key_d     = press_key;
        dur_d     = '0;
      end else if (state_q == HOLD) begin
        if (held) begin
          if (tick_q == TW'(TICKS_PER_UNIT - 1)) begin
            tick_d = '0;
            if (note_duration != DUR_MAX) dur_d = note_duration + DUR_W'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end else begin
          // Release: note_duration is left showing the final value.
          state_d = IDLE;
        end
      end

`ifdef KEY_NOTE_END_EVENT_EN
      // A note ends on release or pre-emption; no unit can complete on that
      // edge because ticking only happens with no rise and the key held.
      if (state_q == HOLD && (press || !held)) begin
        gen     = 1'b1;
        gen_key = act_q;
        gen_dur = note_duration;
        gen_idx = counter;
      end
`else
      if (press) begin
        gen     = 1'b1;
        gen_key = press_key;
        gen_dur = '0;
        gen_idx = counter_d;
      end
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      act_q         <= '0;
      tick_q        <= '0;
      counter       <= '0;
      key_played    <= '0;
      note_duration <= '0;
      ev_valid      <= 1'b0;
      ev_key        <= '0;
      ev_duration   <= '0;
      ev_index      <= '0;
      ev_overflow   <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      tick_q        <= tick_d;
      counter       <= counter_d;
      key_played    <= key_d;
      note_duration <= dur_d;
      if (trigger) prev_q <= keys_in;

      // Load when the entry is empty or being drained on this edge, so an
      // accept and a new event together leave ev_valid high with no bubble.
      if (gen) begin
        if (!ev_valid || ev_ready) begin
          ev_valid    <= 1'b1;
          ev_key      <= gen_key;
          ev_duration <= gen_dur;
          ev_index    <= gen_idx;
        end else begin
          ev_overflow <= 1'b1;
        end
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
